// File: rtl/bsg_credit_return_pkg.sv
// Shared types for the receiver-side credit return path.
package bsg_credit_return_pkg;

    // Credit width at the default pending capacity of 1023.
    localparam int credit_width_default_lp = 10;

    // Return-channel sequencer states.
    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    // Token as seen by the sender-side credit consumer.
    typedef struct packed {
        logic [credit_width_default_lp-1:0] cnt;
    } credit_token_s;

    // Smaller of two non-negative values, for elaboration-time sizing.
    function automatic int unsigned min_u(input int unsigned a, input int unsigned b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/bsg_credit_pending_counter.sv
// Saturating count of credits owed to the sender but not yet launched.
// Increments by one per dequeue and drops by the launched amount.
module bsg_credit_pending_counter #(
    parameter int max_credits_p   = 1023,
    parameter int credit_width_lp = $clog2(max_credits_p + 1)
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       inc_i,
    input  logic [credit_width_lp-1:0] dec_i,
    output logic [credit_width_lp-1:0] pending_o
);

    localparam logic [credit_width_lp:0] max_ext_lp = (credit_width_lp + 1)'(max_credits_p);

    logic [credit_width_lp-1:0] pending_reg;
    logic [credit_width_lp-1:0] pending_next;
    logic [credit_width_lp:0]   sum_ext;
    logic [credit_width_lp:0]   capped_ext;

    // Add the dequeue with one spare bit, clamp at capacity, then remove the launch.
    always_comb begin
        sum_ext      = {1'b0, pending_reg} + {{credit_width_lp{1'b0}}, inc_i};
        capped_ext   = (sum_ext > max_ext_lp) ? max_ext_lp : sum_ext;
        pending_next = capped_ext[credit_width_lp-1:0] - dec_i;
    end

    // Pending register; reset discards every owed credit immediately.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            pending_reg <= '0;
        end else begin
            pending_reg <= pending_next;
        end
    end

    assign pending_o = pending_reg;

    // Receiving more entries than the sender could have credits for is a link bug.
    overflow_check: assert property (@(posedge clk_i) disable iff (reset_i)
        !(inc_i && ({1'b0, pending_reg} == max_ext_lp)));

    // The launch amount is derived from pending, so it can never exceed it.
    underflow_check: assert property (@(posedge clk_i) disable iff (reset_i)
        ({1'b0, dec_i} <= capped_ext));

endmodule

// File: rtl/bsg_credit_return_batcher.sv
// Batches receive-FIFO dequeues into credit tokens for the sender.
// A token launches from IDLE once enough credits are pending (or on flush),
// is held valid in SEND until accepted, and an IDLE cycle always separates tokens.
module bsg_credit_return_batcher
    import bsg_credit_return_pkg::*;
#(
    parameter int max_credits_p   = 1023,
    parameter int batch_size_p    = 4,
    parameter int max_return_p    = 255,
    parameter int credit_width_lp = $clog2(max_credits_p + 1)
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       deq_i,
    input  logic                       flush_i,
    output logic                       credit_v_o,
    output logic [credit_width_lp-1:0] credit_cnt_o,
    input  logic                       credit_ready_i,
    output logic [credit_width_lp-1:0] pending_o,
    output logic                       idle_o
);

    // A token can never carry more than could be pending, so clamp the cap to capacity.
    localparam int unsigned return_cap_lp = min_u(max_return_p, max_credits_p);
    localparam logic [credit_width_lp-1:0] batch_lp  = credit_width_lp'(batch_size_p);
    localparam logic [credit_width_lp-1:0] ret_cap_lp = credit_width_lp'(return_cap_lp);

    state_e                     state_reg;
    state_e                     state_next;
    logic [credit_width_lp-1:0] cnt_reg;
    logic [credit_width_lp-1:0] cnt_next;
    logic [credit_width_lp-1:0] pending;
    logic [credit_width_lp-1:0] launch_amt;
    logic [credit_width_lp-1:0] dec_amt;
    logic                       launch;
    logic                       handshake;

    bsg_credit_pending_counter #(
        .max_credits_p  (max_credits_p),
        .credit_width_lp(credit_width_lp)
    ) pending_counter (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .inc_i    (deq_i),
        .dec_i    (dec_amt),
        .pending_o(pending)
    );

    // Launch size: everything pending, up to the per-token cap.
    always_comb begin
        launch_amt = (pending > ret_cap_lp) ? ret_cap_lp : pending;
    end

    // Sequencer next state; ready is only meaningful while a token is offered.
    always_comb begin
        state_next = state_reg;
        launch     = 1'b0;
        handshake  = 1'b0;
        case (state_reg)
            IDLE: begin
                if ((pending >= batch_lp) || (flush_i && (pending != '0))) begin
                    launch     = 1'b1;
                    state_next = SEND;
                end
            end
            SEND: begin
                if (credit_ready_i) begin
                    handshake  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Token amount is captured at launch and cleared once the sender takes it.
    always_comb begin
        cnt_next = cnt_reg;
        if (launch) begin
            cnt_next = launch_amt;
        end else if (handshake) begin
            cnt_next = '0;
        end
    end

    // A same-cycle dequeue stays in pending; only the launched amount leaves.
    always_comb begin
        dec_amt = launch ? launch_amt : '0;
    end

    // Sequencer state register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Token amount register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign credit_v_o   = (state_reg == SEND);
    assign credit_cnt_o = cnt_reg;
    assign pending_o    = pending;
    assign idle_o       = (pending == '0) && (state_reg == IDLE);

    // Once offered, a token stays valid with a stable amount until accepted.
    valid_hold_check: assert property (@(posedge clk_i) disable iff (reset_i)
        (credit_v_o && !credit_ready_i) |=> (credit_v_o && $stable(credit_cnt_o)));

endmodule

// File: tb/tb_bsg_credit_return_batcher.sv
// Directed bench for the credit return batcher at default parameters.
module tb_bsg_credit_return_batcher;

    logic       clk = 1'b0;
    logic       reset;
    logic       deq;
    logic       flush;
    logic       credit_v;
    logic [9:0] credit_cnt;
    logic       credit_ready;
    logic [9:0] pending;
    logic       idle;

    int checks   = 0;
    int failures = 0;

    bsg_credit_return_batcher dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .deq_i         (deq),
        .flush_i       (flush),
        .credit_v_o    (credit_v),
        .credit_cnt_o  (credit_cnt),
        .credit_ready_i(credit_ready),
        .pending_o     (pending),
        .idle_o        (idle)
    );

    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; deq = 1'b0; flush = 1'b0; credit_ready = 1'b0;
        tick(); tick();
        checks++; if (credit_v !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b want=0", credit_v); end
        checks++; if (credit_cnt !== 10'd0) begin failures++; $display("FAIL reset_cnt got=%0d want=0", credit_cnt); end
        checks++; if (pending !== 10'd0) begin failures++; $display("FAIL reset_pending got=%0d want=0", pending); end
        checks++; if (idle !== 1'b1) begin failures++; $display("FAIL reset_idle got=%0b want=1", idle); end
        reset = 1'b0;
        tick();
        checks++; if (idle !== 1'b1) begin failures++; $display("FAIL post_reset_idle got=%0b want=1", idle); end
    endtask

    // Four dequeues: token of 4 valid two cycles after the fourth, for one cycle.
    task automatic test_batch();
        credit_ready = 1'b1;
        deq = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            checks++; if (pending !== 10'(i)) begin failures++; $display("FAIL batch_pending_%0d got=%0d want=%0d", i, pending, i); end
            checks++; if (credit_v !== 1'b0) begin failures++; $display("FAIL batch_early_valid_%0d got=%0b want=0", i, credit_v); end
        end
        deq = 1'b0;
        tick();
        checks++; if (credit_v !== 1'b1) begin failures++; $display("FAIL batch_valid got=%0b want=1", credit_v); end
        checks++; if (credit_cnt !== 10'd4) begin failures++; $display("FAIL batch_cnt got=%0d want=4", credit_cnt); end
        checks++; if (pending !== 10'd0) begin failures++; $display("FAIL batch_pending_after got=%0d want=0", pending); end
        checks++; if (idle !== 1'b0) begin failures++; $display("FAIL batch_busy got=%0b want=0", idle); end
        if (credit_v) $display("token cnt=%0d (batch)", credit_cnt);
        tick();
        checks++; if (credit_v !== 1'b0) begin failures++; $display("FAIL batch_one_cycle got=%0b want=0", credit_v); end
        checks++; if (credit_cnt !== 10'd0) begin failures++; $display("FAIL batch_cnt_clear got=%0d want=0", credit_cnt); end
        checks++; if (idle !== 1'b1) begin failures++; $display("FAIL batch_idle got=%0b want=1", idle); end
    endtask

    // Three credits sit below threshold until flush forces them out.
    task automatic test_flush();
        credit_ready = 1'b1;
        deq = 1'b1;
        repeat (3) tick();
        deq = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++; if (credit_v !== 1'b0) begin failures++; $display("FAIL flush_hold_valid_%0d got=%0b want=0", i, credit_v); end
            checks++; if (pending !== 10'd3) begin failures++; $display("FAIL flush_hold_pending_%0d got=%0d want=3", i, pending); end
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++; if (credit_v !== 1'b1) begin failures++; $display("FAIL flush_valid got=%0b want=1", credit_v); end
        checks++; if (credit_cnt !== 10'd3) begin failures++; $display("FAIL flush_cnt got=%0d want=3", credit_cnt); end
        checks++; if (pending !== 10'd0) begin failures++; $display("FAIL flush_pending got=%0d want=0", pending); end
        if (credit_v) $display("token cnt=%0d (flush)", credit_cnt);
        tick();
        checks++; if (credit_v !== 1'b0) begin failures++; $display("FAIL flush_done_valid got=%0b want=0", credit_v); end
        checks++; if (idle !== 1'b1) begin failures++; $display("FAIL flush_idle got=%0b want=1", idle); end
    endtask

    // Stalled token holds 4 while dequeues keep arriving; launch cycle overlaps a deq.
    task automatic test_backpressure();
        credit_ready = 1'b0;
        deq = 1'b1;
        repeat (4) tick();
        checks++; if (pending !== 10'd4) begin failures++; $display("FAIL bp_pending_launch got=%0d want=4", pending); end
        tick();
        checks++; if (pending !== 10'd1) begin failures++; $display("FAIL bp_launch_with_deq got=%0d want=1", pending); end
        checks++; if (credit_cnt !== 10'd4) begin failures++; $display("FAIL bp_cnt_first got=%0d want=4", credit_cnt); end
        for (int i = 2; i <= 10; i++) begin
            tick();
            checks++; if (credit_v !== 1'b1) begin failures++; $display("FAIL bp_valid_%0d got=%0b want=1", i, credit_v); end
            checks++; if (credit_cnt !== 10'd4) begin failures++; $display("FAIL bp_cnt_%0d got=%0d want=4", i, credit_cnt); end
            checks++; if (pending !== 10'(i)) begin failures++; $display("FAIL bp_pending_%0d got=%0d want=%0d", i, pending, i); end
        end
        $display("token cnt=%0d (stalled, accepted next)", credit_cnt);
        deq = 1'b0;
        credit_ready = 1'b1;
        tick();
        checks++; if (credit_v !== 1'b0) begin failures++; $display("FAIL bp_gap_valid got=%0b want=0", credit_v); end
        checks++; if (pending !== 10'd10) begin failures++; $display("FAIL bp_gap_pending got=%0d want=10", pending); end
        tick();
        checks++; if (credit_v !== 1'b1) begin failures++; $display("FAIL bp_next_valid got=%0b want=1", credit_v); end
        checks++; if (credit_cnt !== 10'd10) begin failures++; $display("FAIL bp_next_cnt got=%0d want=10", credit_cnt); end
        checks++; if (pending !== 10'd0) begin failures++; $display("FAIL bp_next_pending got=%0d want=0", pending); end
        if (credit_v) $display("token cnt=%0d (after stall)", credit_cnt);
        tick();
        checks++; if (idle !== 1'b1) begin failures++; $display("FAIL bp_idle got=%0b want=1", idle); end
    endtask

    // 604 dequeues under stall: 4 in flight, 600 pending, drained as 4, 255, 255, 90.
    task automatic test_large_drain();
        logic       exp_v   [7];
        logic [9:0] exp_cnt [7];
        logic [9:0] exp_pend[7];
        int         total;
        exp_v    = '{1'b0, 1'b1,    1'b0,    1'b1,    1'b0,   1'b1,   1'b0};
        exp_cnt  = '{10'd0, 10'd255, 10'd0,  10'd255, 10'd0,  10'd90, 10'd0};
        exp_pend = '{10'd600, 10'd345, 10'd345, 10'd90, 10'd90, 10'd0, 10'd0};
        total = 0;
        credit_ready = 1'b0;
        deq = 1'b1;
        repeat (604) tick();
        deq = 1'b0;
        checks++; if (pending !== 10'd600) begin failures++; $display("FAIL drain_loaded got=%0d want=600", pending); end
        checks++; if (credit_cnt !== 10'd4) begin failures++; $display("FAIL drain_stalled_cnt got=%0d want=4", credit_cnt); end
        if (credit_v) begin
            total += int'(credit_cnt);
            $display("token cnt=%0d (drain)", credit_cnt);
        end
        credit_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            checks++; if (credit_v !== exp_v[i]) begin failures++; $display("FAIL drain_valid_%0d got=%0b want=%0b", i, credit_v, exp_v[i]); end
            checks++; if (credit_cnt !== exp_cnt[i]) begin failures++; $display("FAIL drain_cnt_%0d got=%0d want=%0d", i, credit_cnt, exp_cnt[i]); end
            checks++; if (pending !== exp_pend[i]) begin failures++; $display("FAIL drain_pending_%0d got=%0d want=%0d", i, pending, exp_pend[i]); end
            if (credit_v) begin
                total += int'(credit_cnt);
                $display("token cnt=%0d (drain)", credit_cnt);
            end
        end
        checks++; if (total !== 604) begin failures++; $display("FAIL drain_total got=%0d want=604", total); end
        checks++; if (idle !== 1'b1) begin failures++; $display("FAIL drain_idle got=%0b want=1", idle); end
    endtask

    // Reset asserted between edges while a token is offered.
    task automatic test_async_reset();
        credit_ready = 1'b0;
        deq = 1'b1;
        repeat (4) tick();
        deq = 1'b0;
        tick();
        checks++; if (credit_v !== 1'b1) begin failures++; $display("FAIL ar_pre_valid got=%0b want=1", credit_v); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (credit_v !== 1'b0) begin failures++; $display("FAIL ar_valid_drop got=%0b want=0", credit_v); end
        checks++; if (pending !== 10'd0) begin failures++; $display("FAIL ar_pending got=%0d want=0", pending); end
        checks++; if (credit_cnt !== 10'd0) begin failures++; $display("FAIL ar_cnt got=%0d want=0", credit_cnt); end
        #2;
        reset = 1'b0;
        credit_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (credit_v !== 1'b0) begin failures++; $display("FAIL ar_spurious_%0d got=%0b want=0", i, credit_v); end
            checks++; if (idle !== 1'b1) begin failures++; $display("FAIL ar_idle_%0d got=%0b want=1", i, idle); end
        end
    endtask

    initial begin
        test_reset();
        test_batch();
        test_flush();
        test_backpressure();
        test_large_drain();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard stop in case the run never reaches the summary.
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
